prescaler_bank: RTL
===================

# prescaler_bank

Bank of independent, runtime-programmable prescalers producing single-cycle enable pulses for downstream clock-enabled logic in the memory and peripheral subsystems. Each channel has its own ratio, periodic or one-shot mode, and start/stop control, configured through a simple write port. Optionally, a channel can count the ticks of its lower-numbered neighbour to build long periods from narrow counters.

## Interface
Parameters:
- CHANNELS, default 4: number of prescaler channels (1..16).
- W, default 16: ratio and counter width in bits.
- CW, default $clog2(CHANNELS) (minimum 1): width of the channel-select field.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_we  input  1  configuration write strobe, one cycle.
- cfg_ch  input  CW  target channel; writes with cfg_ch ≥ CHANNELS are ignored.
- cfg_ratio  input  W  period N, in counting events.
- cfg_oneshot  input  1  1 = one-shot, 0 = periodic.
- cfg_cascade  input  1  1 = count channel ch-1 pulses; ignored for ch 0.
- start  input  CHANNELS  per-channel start/restart strobe.
- stop  input  CHANNELS  per-channel stop strobe.
- en  output  CHANNELS  registered tick pulses, one cycle wide.
- busy  output  CHANNELS  channel running.

## Operation
- Per-channel registers: ratio_r[W], cnt[W], oneshot_r, cascade_r, run.
- Counting event:
  - Normally every clk cycle.
  - With cascade_r set, it is en[ch-1] as registered in the previous cycle.
- Configuration write:
  - Loads ratio_r, oneshot_r and cascade_r.
  - Clears run and sets cnt to 0.
  - An in-progress pulse sequence is aborted and en stays low.
- Start of channel i:
  - Sets run and loads cnt = ratio_r - 1.
  - If cfg_we targets i in the same cycle, the newly written values are used and the channel runs.
- Stop of channel i: clears run, and en[i] is low from the next cycle.
- Running, on each counting event:
  - cnt ≠ 0: cnt decrements, en low.
  - cnt = 0: en high for one cycle and cnt reloads ratio_r - 1.
  - One-shot mode: on that pulse, run clears instead of reloading.
- No counting event: cnt holds and en is low.
- ratio_r = 0: a start is ignored (run stays 0) and en never asserts.
- ratio_r = 1: a pulse on every counting event.
- Arithmetic: unsigned, wraps never occur. Maximum N = 2^W - 1.
- Simultaneous events on the same channel:
  - stop beats start.
  - start beats the terminal reload; a restart reloads ratio_r - 1.
  - A cfg_we without start beats everything.
- busy = run.

## Timing
- Reset value of all outputs and registers is 0: en = 0, busy = 0, ratio_r = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first action after deassertion is a start or cfg_we.
- Uncascaded channel, ratio N, start sampled at edge t:
  - busy high after edge t.
  - First en pulse after edge t+N, then every N cycles.
- One-shot: busy falls on the same edge that en rises.
- Cascade latency:
  - Channel i counts en[i-1] pulses.
  - With ratios A on channel i-1 and B on channel i, started together, en[i] fires every A·B cycles.
  - The first en[i] comes at t+A·B+1, one register stage later than an equivalent single counter.
- No combinational path from any input to en or busy.

## Configuration
- PRESC_CASCADE_EN defined:
  - cascade_r is implemented.
  - Channel ch ≥ 1 can count en[ch-1].
- Undefined:
  - cascade_r and the event multiplexer are not synthesised.
  - cfg_cascade is ignored and all channels count clk.
  - Behaviour is otherwise identical.

## Test plan
- Reset and idle: after reset with no writes, en = 0 and busy = 0. Starting all channels with ratio 0 leaves busy = 0 for 50 cycles.
- Periodic: ch0 ratio 5, start at t → en[0] high at t+5, t+10, t+15; after a stop at t+12, no pulse at t+15.
- One-shot and ratio 1:
  - ch1 ratio 3 one-shot → single en at t+3, with busy falling on the same edge.
  - ch2 ratio 1 periodic → en high every cycle.
- Collisions:
  - start and stop in the same cycle → busy stays 0.
  - cfg_we(ch0, ratio 4) with start[0] in the same cycle → first en at t+4.
  - A restart at cnt = 0 → no pulse, and a new period of N begins.
- Cascade (with PRESC_CASCADE_EN): ch0 ratio 3, ch1 ratio 4 cascaded, both started at t → en[1] at t+13, t+25, t+37. Without the macro, the same setup gives en[1] every 4 cycles.
- Async reset mid-count: assert rst_n low at ch0 cnt = 2 → en and busy are 0 immediately. After release, with no new start, no pulses occur.

Source files
------------

// File: rtl/prescaler_bank.sv
// Bank of independent programmable prescalers emitting one-cycle enable pulses.
// Define PRESC_CASCADE_EN to let channel ch >= 1 count the pulses of channel ch-1.
module prescaler_bank #(
  parameter int CHANNELS = 4,
  parameter int W        = 16,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [W-1:0]        cfg_ratio,
  input  logic                cfg_oneshot,
  input  logic                cfg_cascade,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] busy
);

  logic [CHANNELS-1:0] en_vec;
  logic [CHANNELS-1:0] run_vec;

  // Sink for cfg_cascade in builds or bank sizes that never consume it.
  logic unused_cfg_cascade;
  assign unused_cfg_cascade = cfg_cascade;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [W-1:0] ratio_reg;
      logic [W-1:0] cnt_reg;
      logic [W-1:0] ratio_next;
      logic         oneshot_reg;
      logic         run_reg;
      logic         en_reg;
      logic         wr;
      logic         ev;

      assign wr         = cfg_we && (cfg_ch == CW'(gi));
      // A start in the same cycle as a write must see the freshly written ratio.
      assign ratio_next = wr ? cfg_ratio : ratio_reg;

`ifdef PRESC_CASCADE_EN
      if (gi > 0) begin : g_casc
        logic cascade_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)  cascade_reg <= 1'b0;
          else if (wr) cascade_reg <= cfg_cascade;
        end
        assign ev = cascade_reg ? en_vec[gi-1] : 1'b1;
      end else begin : g_nocasc
        assign ev = 1'b1;
      end
`else
      assign ev = 1'b1;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ratio_reg   <= '0;
          cnt_reg     <= '0;
          oneshot_reg <= 1'b0;
          run_reg     <= 1'b0;
          en_reg      <= 1'b0;
        end else begin
          en_reg <= 1'b0;
          if (wr) begin
            ratio_reg   <= cfg_ratio;
            oneshot_reg <= cfg_oneshot;
            cnt_reg     <= '0;
            run_reg     <= 1'b0;
          end
          if (stop[gi]) begin
            run_reg <= 1'b0;
          end else if (start[gi]) begin
            run_reg <= (ratio_next != '0);
            cnt_reg <= (ratio_next != '0) ? ratio_next - W'(1) : '0;
          end else if (!wr && run_reg && ev) begin
            if (cnt_reg == '0) begin
              en_reg <= 1'b1;
              if (oneshot_reg) run_reg <= 1'b0;
              else             cnt_reg <= ratio_reg - W'(1);
            end else begin
              cnt_reg <= cnt_reg - W'(1);
            end
          end
        end
      end

      assign en_vec[gi]  = en_reg;
      assign run_vec[gi] = run_reg;
    end
  endgenerate

  assign en   = en_vec;
  assign busy = run_vec;

endmodule
